rvx_fetch_unit: RTL
===================

# rvx_fetch_unit

Instruction-fetch stage for the RVX pipeline. It consumes the `jumpEn`/`jumpAddr`/`stallIF`/`flushIF` controls produced by the hazard/jump controller, and keeps up to 2 requests in flight to an in-order instruction memory. It buffers returned words in a 2-entry queue and drives the IF/ID pipeline register that the controller inspects. It is the producer side of `instIn_IFID` and the consumer side of the controller's redirect/stall/flush outputs.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- Bus width is `BUS_W` (32).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `jumpEnIn` in 1: redirect request, PC-change now.
- `jumpAddrIn` in `BUS_W`: redirect target.
- `stallIFIn` in 1: hold IF/ID contents.
- `flushIFIn` in 1: load bubble into IF/ID.
- `imemReqValidOut` out 1: fetch request valid.
- `imemReqAddrOut` out `BUS_W`: fetch address, equal to `fetchPc`.
- `imemReqReadyIn` in 1: memory accepts the request.
- `imemRespValidIn` in 1: in-order response valid; there is no back-pressure.
- `imemRespDataIn` in `BUS_W`: returned instruction.
- `instOut_IFID` out `BUS_W`: IF/ID instruction.
- `pcOut_IFID` out `BUS_W`: IF/ID PC.
- `validOut_IFID` out 1: IF/ID holds a real instruction.

## Operation
State:
- `fetchPc`
- `inflight` count (0..2)
- in-flight PC FIFO (depth 2)
- `dropCnt` (0..2)
- instruction queue (depth 2, {inst, pc}, head/tail pointers that wrap mod 2)
- IF/ID register

Request side:
- `imemReqValidOut = !rst && (inflight + queueCount) < 2`.
- A request is accepted when valid and ready are both high. On acceptance: push `fetchPc` into the PC FIFO, `inflight++`, and `fetchPc += 4` (mod 2^32, wraps).

Response side:
- Each `imemRespValidIn` pops the PC FIFO and decrements `inflight`.
- If `dropCnt > 0`: discard the word and decrement `dropCnt`.
- Otherwise the word becomes a candidate `{data, pc}`.
- A response arriving while `inflight == 0` is a protocol violation and is ignored.

IF/ID update, in priority order:
1. `rst`.
2. `jumpEnIn`: IF/ID <= {`NOP_INST`, pc 0, valid 0}.
   - `fetchPc <= jumpAddrIn`.
   - Queue cleared.
   - `dropCnt <=` in-flight count after this cycle's accept/response.
   - Any response arriving this cycle is discarded.
3. `flushIFIn`: IF/ID <= bubble. The queue head is not consumed; a candidate response is enqueued.
4. `stallIFIn`: IF/ID held; a candidate is enqueued.
5. Otherwise:
   - If the queue is non-empty: IF/ID <= head with valid 1, then pop. A candidate is enqueued.
   - Else if a candidate exists: IF/ID <= candidate with valid 1 (bypass).
   - Else: IF/ID <= bubble.

Additional rules:
- The credit rule guarantees the queue never overflows. A push and a pop in the same cycle keep the count unchanged.
- Reset mid-transfer: all state is cleared. Any later responses are ignored because `inflight` is 0.

## Timing
Reset values:
- `fetchPc = RESET_PC`.
- `inflight = dropCnt = 0`.
- Queue empty.
- `instOut_IFID = NOP_INST`, `pcOut_IFID = 0`, `validOut_IFID = 0`.
- `imemReqValidOut = 0` while `rst` is high. It rises in the first cycle after reset with `imemReqAddrOut = RESET_PC`.

Latency:
- A response with an empty queue and no stall appears on IF/ID at the edge that samples it, i.e. 1 edge.
- A queued word reaches IF/ID 1 edge after the stall releases.

Redirect:
- `jumpEnIn` sampled at edge N gives `imemReqAddrOut = jumpAddrIn` in cycle N+1.
- The first target instruction reaches IF/ID no earlier than 1 edge after its response.

Credit:
- Counts are registered, so a slot freed at an edge is usable in the next cycle.

Throughput:
- With zero-wait memory (ready=1, response the next cycle), one instruction per cycle is sustained.

## Test plan
- Reset, with ready=1 and a 1-cycle response → addresses 0x0, 0x4, 0x8… issued back-to-back. IF/ID shows pc 0x0, 0x4 on consecutive cycles with valid=1.
- `stallIFIn` held for 3 cycles during streaming → IF/ID is frozen. At most 2 further requests are accepted; `imemReqValidOut` then drops. After release, the queued pcs emerge in order with no loss or duplication.
- `jumpEnIn`=1 with `jumpAddrIn`=0x100 while 2 requests are in flight → the next 2 responses are dropped. The next request address is 0x100, and IF/ID shows a bubble, then pc 0x100.
- `flushIFIn` alone with the queue holding pc 0x8 → IF/ID becomes {0x00000013, valid 0}. On the next cycle IF/ID = pc 0x8.
- `jumpEnIn` and `stallIFIn` asserted together → jump wins and IF/ID becomes a bubble. `fetchPc` wrap test: `jumpAddrIn`=0xFFFFFFFC yields a following fetch address of 0x0.
- `rst` asserted with 2 requests outstanding, then 2 stray responses → all outputs are at reset values and the stray words never reach IF/ID.

Source files
------------

// File: rtl/rvx_fetch_unit.sv
// rvx_fetch_unit -- instruction-fetch stage of the RVX pipeline.
//
// Issues in-order fetch requests to the instruction memory, keeping at most
// two words "owned" at any time (requests in flight plus words waiting in the
// local 2-entry queue). Returned words either go straight into the IF/ID
// register or wait in the queue while the pipeline is stalled or flushed.
// Redirects from the hazard/jump controller discard everything older.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   jumpEnIn/AddrIn    redirect request and target
//   stallIFIn          hold IF/ID
//   flushIFIn          load a bubble into IF/ID
//   imemReq*           request channel (valid/ready, address = fetch PC)
//   imemResp*          in-order response channel, no back-pressure
//   *_IFID             IF/ID pipeline register (instruction, PC, valid)
module rvx_fetch_unit #(
  parameter int                 BUS_W    = 32,
  parameter logic [BUS_W-1:0]   RESET_PC = '0,
  parameter logic [BUS_W-1:0]   NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jumpEnIn,
  input  logic [BUS_W-1:0] jumpAddrIn,
  input  logic             stallIFIn,
  input  logic             flushIFIn,
  output logic             imemReqValidOut,
  output logic [BUS_W-1:0] imemReqAddrOut,
  input  logic             imemReqReadyIn,
  input  logic             imemRespValidIn,
  input  logic [BUS_W-1:0] imemRespDataIn,
  output logic [BUS_W-1:0] instOut_IFID,
  output logic [BUS_W-1:0] pcOut_IFID,
  output logic             validOut_IFID
);

  logic [BUS_W-1:0] fetch_pc;
  logic [1:0]       inflight;
  logic [1:0]       drop_cnt;

  // PCs of requests still awaiting their response, oldest at pf_rd
  logic [BUS_W-1:0] pc_fifo [2];
  logic             pf_wr;
  logic             pf_rd;

  // Returned words waiting for the pipeline to accept them
  logic [BUS_W-1:0] q_inst [2];
  logic [BUS_W-1:0] q_pc   [2];
  logic             q_head;
  logic             q_tail;
  logic [1:0]       q_count;

  logic             accept;
  logic             resp;
  logic [BUS_W-1:0] resp_pc;
  logic             cand;
  logic             advance;
  logic             take_head;
  logic             bypass;
  logic             enq;
  logic [1:0]       inflight_next;

  // Credit check: a new request is only allowed while the words already owned
  // (in flight or queued) leave room, so the queue can never overflow.
  assign imemReqValidOut = !rst && ((3'(inflight) + 3'(q_count)) < 3'd2);
  assign imemReqAddrOut  = fetch_pc;

  // Handshake and response classification for this cycle. A response with
  // nothing in flight is stray (e.g. issued before a reset) and is ignored.
  always_comb begin
    accept        = imemReqValidOut && imemReqReadyIn;
    resp          = imemRespValidIn && (inflight != 2'd0);
    resp_pc       = pc_fifo[pf_rd];
    cand          = resp && (drop_cnt == 2'd0);
    advance       = !jumpEnIn && !flushIFIn && !stallIFIn;
    take_head     = advance && (q_count != 2'd0);
    bypass        = advance && (q_count == 2'd0) && cand;
    enq           = cand && !jumpEnIn && !bypass;
    inflight_next = inflight + 2'(accept) - 2'(resp);
  end

  // All fetch state. A redirect turns every request still outstanding after
  // this cycle into a word to be dropped, and empties the queue; flush and
  // stall keep incoming words in the queue so nothing fetched is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 2'd0;
      drop_cnt      <= 2'd0;
      pf_wr         <= 1'b0;
      pf_rd         <= 1'b0;
      q_head        <= 1'b0;
      q_tail        <= 1'b0;
      q_count       <= 2'd0;
      instOut_IFID  <= NOP_INST;
      pcOut_IFID    <= '0;
      validOut_IFID <= 1'b0;
    end else begin
      inflight <= inflight_next;

      if (accept) begin
        pc_fifo[pf_wr] <= fetch_pc;
        pf_wr          <= ~pf_wr;
      end
      if (resp) begin
        pf_rd <= ~pf_rd;
      end

      if (jumpEnIn) begin
        fetch_pc <= jumpAddrIn;
      end else if (accept) begin
        fetch_pc <= fetch_pc + BUS_W'(4);
      end

      if (jumpEnIn) begin
        drop_cnt <= inflight_next;
      end else if (resp && (drop_cnt != 2'd0)) begin
        drop_cnt <= drop_cnt - 2'd1;
      end

      if (jumpEnIn) begin
        q_head  <= 1'b0;
        q_tail  <= 1'b0;
        q_count <= 2'd0;
      end else begin
        if (enq) begin
          q_inst[q_tail] <= imemRespDataIn;
          q_pc[q_tail]   <= resp_pc;
          q_tail         <= ~q_tail;
        end
        if (take_head) begin
          q_head <= ~q_head;
        end
        q_count <= q_count + 2'(enq) - 2'(take_head);
      end

      if (jumpEnIn || flushIFIn) begin
        instOut_IFID  <= NOP_INST;
        pcOut_IFID    <= '0;
        validOut_IFID <= 1'b0;
      end else if (stallIFIn) begin
        instOut_IFID  <= instOut_IFID;
        pcOut_IFID    <= pcOut_IFID;
        validOut_IFID <= validOut_IFID;
      end else if (take_head) begin
        instOut_IFID  <= q_inst[q_head];
        pcOut_IFID    <= q_pc[q_head];
        validOut_IFID <= 1'b1;
      end else if (bypass) begin
        instOut_IFID  <= imemRespDataIn;
        pcOut_IFID    <= resp_pc;
        validOut_IFID <= 1'b1;
      end else begin
        instOut_IFID  <= NOP_INST;
        pcOut_IFID    <= '0;
        validOut_IFID <= 1'b0;
      end
    end
  end

endmodule
